// File: rtl/uart_receiver_if.sv
// Receive-side result bundle: the last good byte plus its done/frame-error strobes.
// The master drives it and the consumer (RX FIFO / register block) listens.
interface uart_receiver_if;
    logic [7:0] rx_dataOut;
    logic       rx_done_tick;
    logic       frame_error;

    modport master (
        output rx_dataOut,
        output rx_done_tick,
        output frame_error
    );

    modport slave (
        input rx_dataOut,
        input rx_done_tick,
        input frame_error
    );
endinterface

// File: rtl/uart_receiver.sv
// UART receive path: 16x oversampled start detection, LSB-first data shift and stop check.
// Good bytes are presented with a one-clock done pulse; a low stop bit gives a frame_error pulse.
module uart_receiver #(
    parameter int unsigned DBit = 8,
    parameter int unsigned SBit = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            rx,
    uart_receiver_if.master rx_out
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StStart = 3'd1;
    localparam logic [2:0] StData  = 3'd2;
    localparam logic [2:0] StStop  = 3'd3;
    localparam logic [2:0] StBreak = 3'd4;

    localparam logic [4:0] MidStart = 5'd7;
    localparam logic [4:0] MidBit   = 5'd15;
    localparam logic [4:0] StopLast = 5'(SBit - 1);
    localparam logic [2:0] BitLast  = 3'(DBit - 1);
    localparam logic [7:0] DataMask = 8'((9'd1 << DBit) - 9'd1);

    logic       rx_meta;
    logic       rx_sync;
    logic [2:0] state_q, state_d;
    logic [4:0] t_q, t_d;
    logic [2:0] n_q, n_d;
    logic [7:0] sh_q, sh_d;
    logic [7:0] data_q, data_d;
    logic       done_q, done_d;
    logic       ferr_q, ferr_d;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        n_d     = n_q;
        sh_d    = sh_q;
        data_d  = data_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        if (s_tick) begin
            case (state_q)
                StIdle: begin
                    if (!rx_sync) begin
                        state_d = StStart;
                        t_d     = 5'd0;
                    end
                end
                StStart: begin
                    if (t_q == MidStart) begin
                        t_d = 5'd0;
                        n_d = 3'd0;
                        // A line that is high again at mid-start was only a glitch.
                        state_d = rx_sync ? StIdle : StData;
                    end else begin
                        t_d = t_q + 5'd1;
                    end
                end
                StData: begin
                    if (t_q == MidBit) begin
                        sh_d          = sh_q >> 1;
                        sh_d[DBit-1]  = rx_sync;
                        t_d           = 5'd0;
                        if (n_q == BitLast) begin
                            n_d     = 3'd0;
                            state_d = StStop;
                        end else begin
                            n_d = n_q + 3'd1;
                        end
                    end else begin
                        t_d = t_q + 5'd1;
                    end
                end
                StStop: begin
                    if (t_q == StopLast) begin
                        t_d = 5'd0;
                        if (rx_sync) begin
                            data_d  = sh_q & DataMask;
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = StBreak;
                        end
                    end else begin
                        t_d = t_q + 5'd1;
                    end
                end
                StBreak: begin
                    // Hold off until the line returns high so a break is not a new start.
                    if (rx_sync) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            state_q <= StIdle;
            t_q     <= 5'd0;
            n_q     <= 3'd0;
            sh_q    <= 8'd0;
            data_q  <= 8'd0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            state_q <= state_d;
            t_q     <= t_d;
            n_q     <= n_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_out.rx_dataOut   = data_q;
    assign rx_out.rx_done_tick = done_q;
    assign rx_out.frame_error  = ferr_q;

endmodule
